// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: unpacks/classifies two IEEE-754 singles, normalizing denormals one bit per cycle; FP_UNPACK_FTZ_EN flushes denormals to zero
module fp_operand_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sign_a,
    output logic                   sign_b,
    output logic [EXP_W+1:0]       exp_a,
    output logic [EXP_W+1:0]       exp_b,
    output logic [MAN_W:0]         sig_a,
    output logic [MAN_W:0]         sig_b,
    output logic [4:0]             shift_a,
    output logic [4:0]             shift_b,
    output logic [3:0]             cls_a,
    output logic [3:0]             cls_b,
    output logic                   res_sign,
    output logic                   invalid
);
    typedef struct packed {
        logic             s;
        logic [EXP_W+1:0] e;
        logic [MAN_W:0]   m;
        logic [3:0]       c;
    } op_t;

    localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, HOLD = 2'd2;
    localparam logic [EXP_W+1:0] EXP_ONE = 1;

    function automatic op_t unpack(input logic [EXP_W+MAN_W:0] v);
        op_t o;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic z, d, i, n;
        e = v[MAN_W +: EXP_W];
        m = v[MAN_W-1:0];
        z = (e == '0) && (m == '0);
        d = (e == '0) && (m != '0);
        i = (&e) && (m == '0);
        n = (&e) && (m != '0);
        o.s = v[EXP_W+MAN_W];
`ifdef FP_UNPACK_FTZ_EN
        o.c = {n, i, d, z | d};
        o.m = (z | d) ? '0 : {1'b1, m};
        o.e = (z | d) ? '0 : {2'b00, e};
`else
        o.c = {n, i, d, z};
        o.m = z ? '0 : {~d, m};
        o.e = z ? '0 : d ? EXP_ONE : {2'b00, e};
`endif
        return o;
    endfunction

    logic [1:0] st;
    op_t        ua, ub;
    logic       need_a, need_b, done, go_norm;

    assign ua        = unpack(op_a);
    assign ub        = unpack(op_b);
    assign in_ready  = (st == IDLE);
    assign out_valid = (st == HOLD);
    assign need_a    = cls_a[1] & ~sig_a[MAN_W];
    assign need_b    = cls_b[1] & ~sig_b[MAN_W];
    assign done      = ~(need_a & ~sig_a[MAN_W-1]) & ~(need_b & ~sig_b[MAN_W-1]);
`ifdef FP_UNPACK_FTZ_EN
    assign go_norm   = 1'b0;
`else
    assign go_norm   = ua.c[1] | ub.c[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
            sig_a    <= '0;
            sig_b    <= '0;
            shift_a  <= '0;
            shift_b  <= '0;
            cls_a    <= '0;
            cls_b    <= '0;
            res_sign <= 1'b0;
            invalid  <= 1'b0;
        end else if (st == IDLE) begin
            if (in_valid) begin
                st       <= go_norm ? NORM : HOLD;
                sign_a   <= ua.s;
                sign_b   <= ub.s;
                exp_a    <= ua.e;
                exp_b    <= ub.e;
                sig_a    <= ua.m;
                sig_b    <= ub.m;
                shift_a  <= '0;
                shift_b  <= '0;
                cls_a    <= ua.c;
                cls_b    <= ub.c;
                res_sign <= ua.s ^ ub.s;
                invalid  <= ua.c[3] | ub.c[3] | (ua.c[2] & ub.c[0]) | (ua.c[0] & ub.c[2]);
            end
        end else if (st == NORM) begin
            if (done)
                st <= HOLD;
            if (need_a) begin
                sig_a   <= sig_a << 1;
                exp_a   <= exp_a - EXP_ONE;
                shift_a <= shift_a + 5'd1;
            end
            if (need_b) begin
                sig_b   <= sig_b << 1;
                exp_b   <= exp_b - EXP_ONE;
                shift_b <= shift_b + 5'd1;
            end
        end else if (out_ready) begin
            st <= IDLE;
        end
    end
endmodule
